// File: rtl/nec_ir_pkg.sv
// Shared types, error codes and timing helpers for the NEC IR receiver.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StCheck,
    StRptMark
  } nec_state_e;

  localparam logic [2:0] ErrLeadMark  = 3'd1;
  localparam logic [2:0] ErrLeadSpace = 3'd2;
  localparam logic [2:0] ErrMark      = 3'd3;
  localparam logic [2:0] ErrSpace     = 3'd4;
  localparam logic [2:0] ErrCmdChk    = 3'd5;
  localparam logic [2:0] ErrAddrChk   = 3'd6;
  localparam logic [2:0] ErrOrphanRpt = 3'd7;

  localparam int unsigned NomLeadMarkUs   = 9000;
  localparam int unsigned NomFrameSpaceUs = 4500;
  localparam int unsigned NomRptSpaceUs   = 2250;
  localparam int unsigned NomBitMarkUs    = 560;
  localparam int unsigned NomZeroSpaceUs  = 560;
  localparam int unsigned NomOneSpaceUs   = 1690;
  localparam int unsigned NomStopMarkUs   = 560;

  // Clock count for a duration scaled by pct/100; 64-bit to survive fast clocks.
  function automatic int unsigned nec_cnt(int unsigned clk_hz, int unsigned us,
                                          int unsigned pct);
    logic [63:0] prod;
    prod = 64'(clk_hz) * 64'(us) * 64'(pct);
    return 32'(prod / 64'd100_000_000);
  endfunction

  function automatic logic in_win(logic [31:0] v, int unsigned lo, int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/nec_ir_rcv_filter.sv
// ir_in_filter: 2-FF synchronizer plus FILT_LEN-sample debounce with edge pulses.
module ir_in_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level   <= 1'b1;
      cnt_q   <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync2_q == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        level <= sync2_q;
        cnt_q <= '0;
        rise  <= sync2_q;
        fall  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nec_ir_rcv.sv
// NEC IR frame decoder with repeat qualification and error reporting.
// Define NEC_EXT_ADDR_EN to accept extended (non-complemented) addresses.
module nec_ir_rcv
  import nec_ir_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned TOL_PCT       = 20,
  parameter int unsigned FILT_LEN      = 4,
  parameter int unsigned REPEAT_WIN_MS = 120
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        infrared_in,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        ext_addr,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        busy
);

`ifdef NEC_EXT_ADDR_EN
  localparam bit ExtEn = 1'b1;
`else
  localparam bit ExtEn = 1'b0;
`endif

  localparam int unsigned LoPct  = 100 - TOL_PCT;
  localparam int unsigned HiPct  = 100 + TOL_PCT;
  localparam int unsigned LmMin  = nec_cnt(CLK_FREQ_HZ, NomLeadMarkUs, LoPct);
  localparam int unsigned LmMax  = nec_cnt(CLK_FREQ_HZ, NomLeadMarkUs, HiPct);
  localparam int unsigned LsMin  = nec_cnt(CLK_FREQ_HZ, NomFrameSpaceUs, LoPct);
  localparam int unsigned LsMax  = nec_cnt(CLK_FREQ_HZ, NomFrameSpaceUs, HiPct);
  localparam int unsigned RsMin  = nec_cnt(CLK_FREQ_HZ, NomRptSpaceUs, LoPct);
  localparam int unsigned RsMax  = nec_cnt(CLK_FREQ_HZ, NomRptSpaceUs, HiPct);
  localparam int unsigned BmMin  = nec_cnt(CLK_FREQ_HZ, NomBitMarkUs, LoPct);
  localparam int unsigned BmMax  = nec_cnt(CLK_FREQ_HZ, NomBitMarkUs, HiPct);
  localparam int unsigned ZsMin  = nec_cnt(CLK_FREQ_HZ, NomZeroSpaceUs, LoPct);
  localparam int unsigned ZsMax  = nec_cnt(CLK_FREQ_HZ, NomZeroSpaceUs, HiPct);
  localparam int unsigned OsMin  = nec_cnt(CLK_FREQ_HZ, NomOneSpaceUs, LoPct);
  localparam int unsigned OsMax  = nec_cnt(CLK_FREQ_HZ, NomOneSpaceUs, HiPct);
  localparam int unsigned SmMin  = nec_cnt(CLK_FREQ_HZ, NomStopMarkUs, LoPct);
  localparam int unsigned SmMax  = nec_cnt(CLK_FREQ_HZ, NomStopMarkUs, HiPct);
  localparam int unsigned RptCnt = nec_cnt(CLK_FREQ_HZ, REPEAT_WIN_MS * 1000, 100);
  localparam int unsigned CntW   = $clog2(LmMax + 2);
  localparam int unsigned GapW   = $clog2(RptCnt + 1);

  nec_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [GapW-1:0] gap_q;
  logic [4:0]      bit_cnt_q;
  logic [31:0]     shift_q;
  logic            good_q, ext_q;
  logic            filt_level, rise, fall;
  logic [31:0]     cnt_w, gap_w, tmo_max;
  logic            timeout, is_zero, is_one;
  logic [7:0]      a0, a1, c0, c1;

  ir_in_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (infrared_in),
    .level     (filt_level),
    .rise      (rise),
    .fall      (fall)
  );

  assign cnt_w    = 32'(cnt_q);
  assign gap_w    = 32'(gap_q);
  assign is_zero  = in_win(cnt_w, ZsMin, ZsMax);
  assign is_one   = in_win(cnt_w, OsMin, OsMax);
  assign {c1, c0, a1, a0} = shift_q;
  assign ext_addr = ExtEn ? ext_q : 1'b0;
  assign busy     = (state_q != StIdle);

  always_comb begin
    tmo_max = 32'hFFFF_FFFF;
    unique case (state_q)
      StLeadMark:                      tmo_max = LmMax;
      StLeadSpace:                     tmo_max = LsMax;
      StBitMark, StStopMark, StRptMark: tmo_max = BmMax;
      StBitSpace:                      tmo_max = OsMax;
      default:                         ;
    endcase
  end
  assign timeout = (cnt_w > tmo_max);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      gap_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      good_q       <= 1'b0;
      ext_q        <= 1'b0;
      addr         <= '0;
      cmd          <= '0;
      frame_valid  <= 1'b0;
      repeat_valid <= 1'b0;
      err          <= 1'b0;
      err_code     <= '0;
    end else begin
      frame_valid  <= 1'b0;
      repeat_valid <= 1'b0;
      err          <= 1'b0;
      if (rise || fall)       cnt_q <= '0;
      else if (cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
      if (frame_valid || repeat_valid) gap_q <= '0;
      else if (gap_w < RptCnt)         gap_q <= gap_q + 1'b1;

      // Edges take priority over a same-cycle timeout in every state.
      unique case (state_q)
        StIdle: if (fall && !filt_level) state_q <= StLeadMark;
        StLeadMark: begin
          if (rise && in_win(cnt_w, LmMin, LmMax)) state_q <= StLeadSpace;
          else if (rise || timeout) begin
            state_q <= StIdle; err <= 1'b1; err_code <= ErrLeadMark;
          end
        end
        StLeadSpace: begin
          if (fall && in_win(cnt_w, LsMin, LsMax)) begin
            state_q   <= StBitMark;
            bit_cnt_q <= '0;
          end else if (fall && in_win(cnt_w, RsMin, RsMax)) begin
            state_q <= StRptMark;
          end else if (fall || timeout) begin
            state_q <= StIdle; err <= 1'b1; err_code <= ErrLeadSpace;
          end
        end
        StBitMark: begin
          if (rise && in_win(cnt_w, BmMin, BmMax)) state_q <= StBitSpace;
          else if (rise || timeout) begin
            state_q <= StIdle; err <= 1'b1; err_code <= ErrMark;
          end
        end
        StBitSpace: begin
          if (fall && (is_zero || is_one)) begin
            shift_q   <= {is_one, shift_q[31:1]};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            state_q   <= (bit_cnt_q == 5'd31) ? StStopMark : StBitMark;
          end else if (fall || timeout) begin
            state_q <= StIdle; err <= 1'b1; err_code <= ErrSpace;
          end
        end
        StStopMark: begin
          // Verdict is registered on the stop rise so strobes land one cycle later.
          if (rise && in_win(cnt_w, SmMin, SmMax)) begin
            state_q <= StCheck;
            if (c1 != ~c0) begin
              err <= 1'b1; err_code <= ErrCmdChk;
            end else if (a1 == ~a0) begin
              addr <= {8'h00, a0}; cmd <= c0; ext_q <= 1'b0;
              frame_valid <= 1'b1; good_q <= 1'b1;
            end else if (ExtEn) begin
              addr <= {a1, a0}; cmd <= c0; ext_q <= 1'b1;
              frame_valid <= 1'b1; good_q <= 1'b1;
            end else begin
              err <= 1'b1; err_code <= ErrAddrChk;
            end
          end else if (rise || timeout) begin
            state_q <= StIdle; err <= 1'b1; err_code <= ErrMark;
          end
        end
        StCheck: state_q <= fall ? StLeadMark : StIdle;
        StRptMark: begin
          if (rise && in_win(cnt_w, BmMin, BmMax)) begin
            state_q <= StIdle;
            if (good_q && (gap_w < RptCnt)) repeat_valid <= 1'b1;
            else begin
              err <= 1'b1; err_code <= ErrOrphanRpt;
            end
          end else if (rise || timeout) begin
            state_q <= StIdle; err <= 1'b1; err_code <= ErrMark;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nec_ir_rcv.sv
// Scoreboard bench for nec_ir_rcv: randomized NEC waveforms vs. a byte-level model.
module tb_nec_ir_rcv;

  localparam int unsigned ClkHz  = 50_000;
  localparam int unsigned WinMs  = 120;
  localparam longint      RptWin = longint'(ClkHz) / 1000 * WinMs;

  typedef struct {
    int          kind;  // 0 frame, 1 repeat, 2 error
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        ext;
    logic [2:0]  code;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        infrared_in = 1'b1;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic        ext_addr, frame_valid, repeat_valid, err, busy;
  logic [2:0]  err_code;

  nec_ir_rcv #(
    .CLK_FREQ_HZ   (ClkHz),
    .TOL_PCT       (20),
    .FILT_LEN      (4),
    .REPEAT_WIN_MS (WinMs)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .infrared_in  (infrared_in),
    .addr         (addr),
    .cmd          (cmd),
    .ext_addr     (ext_addr),
    .frame_valid  (frame_valid),
    .repeat_valid (repeat_valid),
    .err          (err),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #10 sys_clk = ~sys_clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  exp_t   q[$];

  // Reference model state
  logic [15:0] m_addr = '0;
  logic [7:0]  m_cmd = '0;
  logic        m_ext = 1'b0;
  bit          m_seen = 1'b0;
  longint      m_last = 0;

  always @(posedge sys_clk) cyc++;

  task automatic cmp(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cyc_of(input longint us);
    return int'(us * ClkHz / 1_000_000);
  endfunction

  // Nominal length with up to +/-8% random jitter.
  function automatic int jit(input int nom);
    int j;
    j = nom * 8 / 100;
    return nom - j + int'($urandom_range(2 * j, 0));
  endfunction

  exp_t mon_e;
  int   mon_k;
  always @(negedge sys_clk) begin
    if (sys_rst_n && (frame_valid || repeat_valid || err)) begin
      mon_k = frame_valid ? 0 : (repeat_valid ? 1 : 2);
      cmp("one_strobe", int'(frame_valid) + int'(repeat_valid) + int'(err), 1);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d, expected none", mon_k);
      end else begin
        mon_e = q.pop_front();
        cmp("event_kind", mon_k, mon_e.kind);
        cmp("addr", addr, mon_e.addr);
        cmp("cmd", cmd, mon_e.cmd);
        cmp("ext_addr", ext_addr, mon_e.ext);
        if (mon_e.kind == 2) cmp("err_code", err_code, mon_e.code);
      end
    end
  end

  task automatic push_err(input logic [2:0] code);
    exp_t e;
    e.kind = 2; e.code = code; e.addr = m_addr; e.cmd = m_cmd; e.ext = m_ext;
    q.push_back(e);
  endtask

  task automatic expect_frame(input logic [7:0] a0, a1, c0, c1, input longint t_end);
    exp_t e;
    e.kind = 2;
    e.code = 3'd0;
    if (c1 != ~c0) e.code = 3'd5;
    else if (a1 == ~a0) begin
      e.kind = 0; m_addr = {8'h00, a0}; m_ext = 1'b0;
    end else begin
`ifdef NEC_EXT_ADDR_EN
      e.kind = 0; m_addr = {a1, a0}; m_ext = 1'b1;
`else
      e.code = 3'd6;
`endif
    end
    if (e.kind == 0) begin
      m_cmd = c0; m_seen = 1'b1; m_last = t_end;
    end
    e.addr = m_addr; e.cmd = m_cmd; e.ext = m_ext;
    q.push_back(e);
  endtask

  task automatic mark(input int n);
    @(negedge sys_clk) infrared_in = 1'b0;
    repeat (n) @(negedge sys_clk);
    infrared_in = 1'b1;
  endtask

  // High space of n cycles, optionally split by a 2-cycle low glitch.
  task automatic space(input int n, input bit glitch);
    int h;
    h = n / 2;
    if (glitch) begin
      repeat (h) @(negedge sys_clk);
      infrared_in = 1'b0;
      repeat (2) @(negedge sys_clk);
      infrared_in = 1'b1;
      repeat (n - h - 2) @(negedge sys_clk);
    end else begin
      repeat (n) @(negedge sys_clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] a0, a1, c0, c1, input int nbits,
                            input bit glitch);
    logic [31:0] data;
    int          len;
    data = {c1, c0, a1, a0};
    mark(jit(cyc_of(9000)));
    cmp("busy_in_frame", busy, 1);
    space(jit(cyc_of(4500)), 1'b0);
    for (int i = 0; i < nbits; i++) begin
      mark(jit(cyc_of(560)));
      space(jit(cyc_of(data[i] ? 1690 : 560)), glitch);
    end
    if (nbits == 32) begin
      len = jit(cyc_of(560));
      expect_frame(a0, a1, c0, c1, cyc + len);
      mark(len);
    end
  endtask

  // Repeat whose final rise lands end_gap cycles after the last good event.
  task automatic send_repeat(input longint end_gap);
    int     lm, rs, bm;
    longint idle, t_end;
    exp_t   e;
    lm = jit(cyc_of(9000));
    rs = jit(cyc_of(2250));
    bm = jit(cyc_of(560));
    idle = m_last + end_gap - cyc - (lm + rs + bm);
    if (idle < 10) idle = 10;
    repeat (idle) @(negedge sys_clk);
    mark(lm);
    space(rs, 1'b0);
    t_end = cyc + bm;
    if (m_seen && (t_end - m_last) < RptWin) begin
      e.kind = 1; e.code = 3'd0; m_last = t_end;
      e.addr = m_addr; e.cmd = m_cmd; e.ext = m_ext;
      q.push_back(e);
    end else begin
      push_err(3'd7);
    end
    mark(bm);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    cmp("pending_events", q.size(), 0);
    q.delete();
    repeat (20) @(negedge sys_clk);
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_addr"}, addr, 0);
    cmp({tag, "_cmd"}, cmd, 0);
    cmp({tag, "_ext"}, ext_addr, 0);
    cmp({tag, "_strobes"}, {frame_valid, repeat_valid, err}, 0);
    cmp({tag, "_err_code"}, err_code, 0);
    cmp({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra0, ra1, rc0, rc1;
    repeat (5) @(negedge sys_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);

    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 32, 1'b0);
    drain();
    send_repeat(longint'(cyc_of(40_000)));
    drain();
    send_repeat(longint'(cyc_of(200_000)));
    drain();

    send_frame(8'h00, 8'hFF, 8'h45, 8'hBB, 32, 1'b0);
    drain();

    push_err(3'd1);
    mark(cyc_of(6000));
    drain();
    push_err(3'd1);
    mark(cyc_of(12_000));
    drain();

    send_frame(8'h34, 8'h12, 8'h56, 8'hA9, 32, 1'b0);
    drain();

    for (int k = 0; k < 3; k++) begin
      ra0 = 8'($urandom);
      ra1 = $urandom_range(1, 0) ? ~ra0 : 8'($urandom);
      rc0 = 8'($urandom);
      rc1 = ($urandom_range(3, 0) == 0) ? 8'($urandom) : ~rc0;
      send_frame(ra0, ra1, rc0, rc1, 32, 1'b0);
      drain();
    end

    send_frame(8'h10, 8'hEF, 8'h22, 8'hDD, 32, 1'b1);
    drain();

    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 16, 1'b0);
    @(negedge sys_clk) sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("midreset");
    m_addr = '0; m_cmd = '0; m_ext = 1'b0; m_seen = 1'b0;
    q.delete();
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    send_repeat(longint'(cyc_of(40_000)));
    drain();
    send_frame(8'h01, 8'hFE, 8'h0C, 8'hF3, 32, 1'b0);
    drain();
    cmp("idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
